// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-coded stream packer: tuple layout,
// marker bytes and the flush FSM state encoding.
package jpeg_pkg;

    localparam int SYM_TUPLE_W = 32;

    localparam int CODE_MSB = 31;
    localparam int CODE_LSB = 24;
    localparam int LEN_MSB  = 23;
    localparam int LEN_LSB  = 16;
    localparam int VAL_MSB  = 15;
    localparam int VAL_LSB  = 8;
    localparam int SIZE_MSB = 7;
    localparam int SIZE_LSB = 0;

    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF_BYTE         = 8'h00;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_PAD,
        FL_DRAIN
    } flush_st_e;

endpackage

// File: rtl/jpeg_bit_merge.sv
// Combinational append of an MSB-aligned code and an LSB-aligned value into
// the MSB-first bit accumulator at fill position cnt_i.
module jpeg_bit_merge #(
    parameter int BUF_W = 32,
    parameter int CNT_W = 6
) (
    input  logic [BUF_W-1:0] acc_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [7:0]       code_i,
    input  logic [3:0]       code_len_i,
    input  logic [7:0]       value_i,
    input  logic [3:0]       value_size_i,
    output logic [BUF_W-1:0] acc_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [7:0]       code_m;
    logic [7:0]       val_m;
    logic [7:0]       val_al;
    logic [15:0]      field;
    logic [BUF_W-1:0] field_w;

    always_comb begin
        // Keep only the live bits so stale low code / high value bits never leak in.
        code_m  = code_i & ~(8'hFF >> code_len_i);
        val_m   = value_i & ~(8'hFF << value_size_i);
        val_al  = val_m << (4'd8 - value_size_i);
        field   = {code_m, 8'h00} | ({val_al, 8'h00} >> code_len_i);
        field_w = {field, {(BUF_W-16){1'b0}}} >> cnt_i;
        acc_o   = acc_i | field_w;
        cnt_o   = cnt_i + CNT_W'(code_len_i) + CNT_W'(value_size_i);
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs Huffman symbol tuples MSB-first into a JPEG entropy-coded byte stream
// with 0xFF/0x00 stuffing and 1-padding of the final byte on flush.
module jpeg_bit_packer
    import jpeg_pkg::*;
#(
    parameter int BUF_W     = 32,
    parameter int MAX_FIELD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SYM_TUPLE_W-1:0] sym_tuple,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_byte,
    output logic                   len_err
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] acc_q, acc_d, acc_sh, acc_mg;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sh, cnt_mg;
    logic             stuff_q, stuff_d;
    logic             len_err_q, len_err_d;
    flush_st_e        st_q, st_d;

    logic       flushing;
    logic       accept;
    logic       out_fire;
    logic [7:0] code_len, value_size;
    logic [3:0] len_c, size_c;
    logic       len_bad;
    logic [BUF_W-1:0] pad_mask;

    assign flushing   = (st_q != FL_IDLE);
    assign in_ready   = !flushing && (cnt_q <= CNT_W'(BUF_W - 16));
    assign out_valid  = stuff_q || (cnt_q >= CNT_W'(8));
    assign out_byte   = stuff_q ? STUFF_BYTE : acc_q[BUF_W-1 -: 8];
    assign len_err    = len_err_q;
    assign out_fire   = out_valid && out_ready;
    // A flush request wins over a tuple offered in the same cycle.
    assign accept     = in_valid && in_ready && !flush_req;

    assign code_len   = sym_tuple[LEN_MSB:LEN_LSB];
    assign value_size = sym_tuple[SIZE_MSB:SIZE_LSB];
    assign len_c      = (code_len   > 8'(MAX_FIELD)) ? 4'(MAX_FIELD) : code_len[3:0];
    assign size_c     = (value_size > 8'(MAX_FIELD)) ? 4'(MAX_FIELD) : value_size[3:0];
    assign len_bad    = (code_len > 8'(MAX_FIELD)) || (value_size > 8'(MAX_FIELD));
    assign pad_mask   = ({BUF_W{1'b1}} >> cnt_q) & ~({BUF_W{1'b1}} >> 8);

    // Emit stage: a byte leaving this cycle is removed before any append.
    always_comb begin
        acc_sh  = acc_q;
        cnt_sh  = cnt_q;
        stuff_d = stuff_q;
        if (out_fire) begin
            if (stuff_q) begin
                stuff_d = 1'b0;
            end else begin
                acc_sh  = acc_q << 8;
                cnt_sh  = cnt_q - CNT_W'(8);
                stuff_d = (acc_q[BUF_W-1 -: 8] == JPEG_MARKER_PREFIX);
            end
        end
    end

    jpeg_bit_merge #(
        .BUF_W (BUF_W),
        .CNT_W (CNT_W)
    ) u_merge (
        .acc_i        (acc_sh),
        .cnt_i        (cnt_sh),
        .code_i       (sym_tuple[CODE_MSB:CODE_LSB]),
        .code_len_i   (len_c),
        .value_i      (sym_tuple[VAL_MSB:VAL_LSB]),
        .value_size_i (size_c),
        .acc_o        (acc_mg),
        .cnt_o        (cnt_mg)
    );

    always_comb begin
        acc_d      = accept ? acc_mg : acc_sh;
        cnt_d      = accept ? cnt_mg : cnt_sh;
        len_err_d  = len_err_q | (accept && len_bad);
        st_d       = st_q;
        flush_done = 1'b0;
        unique case (st_q)
            FL_IDLE: begin
                if (flush_req) st_d = FL_PAD;
            end
            FL_PAD: begin
                if (!stuff_q && cnt_q == '0) begin
                    flush_done = 1'b1;
                    st_d       = FL_IDLE;
                end else if (!stuff_q && cnt_q < CNT_W'(8)) begin
                    // No byte can be presented here, so nothing else touches acc.
                    acc_d = acc_q | pad_mask;
                    cnt_d = CNT_W'(8);
                    st_d  = FL_DRAIN;
                end
            end
            FL_DRAIN: begin
                if (!stuff_q && cnt_q == '0) begin
                    flush_done = 1'b1;
                    st_d       = FL_IDLE;
                end
            end
            default: st_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            stuff_q   <= 1'b0;
            len_err_q <= 1'b0;
            st_q      <= FL_IDLE;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            stuff_q   <= stuff_d;
            len_err_q <= len_err_d;
            st_q      <= st_d;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed bench for jpeg_bit_packer: hand-computed byte streams, stuffing,
// padding, backpressure, length saturation and mid-stream reset.
module tb_jpeg_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] sym_tuple = '0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        len_err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    jpeg_bit_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sym_tuple  (sym_tuple),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .len_err    (len_err)
    );

    // Inputs change just after posedge, so negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) q.push_back(out_byte);
        if (rst_n && flush_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int n, input logic [31:0] exp_w);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < q.size()) chk(tag, {24'h0, q[i]}, {24'h0, exp_w[31-8*i -: 8]});
    endtask

    task automatic send(input string tag, input logic [31:0] t);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        sym_tuple = t;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, n < 200, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input string tag);
        int start = done_cnt;
        int n = 0;
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        while (done_cnt == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_flush_done_once"}, done_cnt - start, 1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 8'h00);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_len_err", len_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: 11|101 then pad 111 -> EF
        q.delete();
        send("t1", 32'hC0_02_05_03);
        @(negedge clk);
        chk("t1_no_byte_below_8", out_valid, 0);
        do_flush("t1");
        chk_q("t1_bytes", 1, 32'hEF000000);
        chk("t1_len_err", len_err, 0);

        // 2: two FF codes -> both stuffed, no pad
        q.delete();
        send("t2a", 32'hFF_08_00_00);
        send("t2b", 32'hFF_08_00_00);
        do_flush("t2");
        chk_q("t2_bytes", 4, 32'hFF00FF00);

        // 3: single 1 bit padded to FF, which is then stuffed
        q.delete();
        send("t3", 32'h80_01_00_00);
        do_flush("t3");
        chk_q("t3_bytes", 2, 32'hFF000000);

        // 4: backpressure: A5, 0011|1100, 111|11110, 81
        q.delete();
        out_ready = 1'b0;
        send("t4a", 32'hA5_08_00_00);
        send("t4b", 32'h30_04_0C_04);
        send("t4c", 32'hE0_03_1E_05);
        @(negedge clk);
        chk("t4_in_ready_full", in_ready, 0);
        chk("t4_out_byte_held", out_byte, 8'hA5);
        @(posedge clk); #1;
        in_valid = 1'b1;
        sym_tuple = 32'h81_08_00_00;
        repeat (6) @(negedge clk);
        chk("t4_in_ready_stall", in_ready, 0);
        chk("t4_no_bytes_while_stalled", q.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t4_resume_timeout", n < 100, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do_flush("t4");
        chk_q("t4_bytes", 4, 32'hA53CFE81);

        // 5: oversize lengths clamp to 8+8 ones
        q.delete();
        send("t5", 32'hFF_0B_FF_0C);
        @(negedge clk);
        chk("t5_len_err_set", len_err, 1);
        do_flush("t5");
        chk_q("t5_bytes", 4, 32'hFF00FF00);
        chk("t5_len_err_sticky", len_err, 1);

        // 6: reset with 10100|01010101 buffered
        q.delete();
        out_ready = 1'b0;
        send("t6", 32'hA0_05_55_08);
        @(negedge clk);
        chk("t6_pre_out_valid", out_valid, 1);
        chk("t6_pre_in_ready", in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_len_err", len_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        q.delete();
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        chk("t6_empty_flush_done_next", flush_done, 1);
        repeat (4) @(negedge clk);
        chk("t6_no_bytes", q.size(), 0);
        chk("t6_out_byte", out_byte, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
